// File: rtl/ooo_issue_scheduler.sv
// Out-of-order dispatch/issue scheduler.
// Instructions enter an age-ordered circular window, issue oldest-ready first
// (one ALU op and one load per cycle) under RAW/WAR/WAW ordering against older
// entries, complete out of order through two writeback ports and retire in
// program order from the head. HALT closes dispatch until reset.
module ooo_issue_scheduler #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    // dispatch
    input  logic             disp_valid,
    input  logic [11:0]      disp_instr,
    output logic             disp_ready,
    // ALU issue
    output logic             alu_valid,
    output logic [2:0]       alu_op,
    output logic [2:0]       alu_rd,
    output logic [2:0]       alu_rs1,
    output logic [2:0]       alu_rs2,
    output logic [TAG_W-1:0] alu_tag,
    // load issue
    output logic             ld_valid,
    input  logic             ld_ready,
    output logic [2:0]       ld_rd,
    output logic [2:0]       ld_addr,
    output logic [TAG_W-1:0] ld_tag,
    // completion
    input  logic             alu_wb_valid,
    input  logic [TAG_W-1:0] alu_wb_tag,
    input  logic             ld_wb_valid,
    input  logic [TAG_W-1:0] ld_wb_tag,
    // retire and status
    output logic             retire_valid,
    output logic [TAG_W-1:0] retire_tag,
    output logic [TAG_W:0]   count,
    output logic             halted
);

    typedef enum logic [1:0] {StEmpty, StWait, StIssued, StDone} ent_st_e;

    localparam logic [2:0]     OpLd   = 3'b101;
    localparam logic [2:0]     OpHalt = 3'b111;
    localparam logic [TAG_W:0] DepthC = (TAG_W+1)'(DEPTH);

    // Window storage
    ent_st_e    st_q    [DEPTH];
    ent_st_e    st_d    [DEPTH];
    logic       is_ld_q [DEPTH];
    logic [2:0] op_q    [DEPTH];
    logic [2:0] rd_q    [DEPTH];
    logic [2:0] rs1_q   [DEPTH];
    logic [2:0] rs2_q   [DEPTH];

    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;
    logic             halt_seen_q, halt_seen_d;

    // Dispatch decode
    logic [2:0] d_op;
    logic       d_fire;
    logic       d_alloc;
    logic       d_halt;

    // Scheduling
    logic [TAG_W-1:0] age [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic             alu_found;
    logic [TAG_W-1:0] alu_sel;
    logic             ld_found;
    logic [TAG_W-1:0] ld_sel;

    assign d_op       = disp_instr[11:9];
    assign disp_ready = (count_q < DepthC) && !halt_seen_q;
    assign d_fire     = disp_valid && disp_ready;
    // Opcodes 000..101 take an entry; 110 is swallowed and 111 only sets halt.
    assign d_alloc    = d_fire && (d_op <= OpLd);
    assign d_halt     = d_fire && (d_op == OpHalt);

    // Distance from head: smaller means older.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            age[i] = TAG_W'(i) - head_q;
        end
    end

    // Per-entry readiness against every older entry (RAW, WAW, WAR).
    always_comb begin
        rdy = '0;
        for (int e = 0; e < int'(DEPTH); e++) begin
            rdy[e] = (st_q[e] == StWait);
            for (int o = 0; o < int'(DEPTH); o++) begin
                if (age[o] < age[e]) begin
                    // An older producer still in flight blocks readers and writers of its rd.
                    if (st_q[o] == StWait || st_q[o] == StIssued) begin
                        if (!is_ld_q[e] && (rd_q[o] == rs1_q[e] || rd_q[o] == rs2_q[e])) begin
                            rdy[e] = 1'b0;
                        end
                        if (rd_q[o] == rd_q[e]) begin
                            rdy[e] = 1'b0;
                        end
                    end
                    // An older reader that has not issued yet still needs its sources intact.
                    if (st_q[o] == StWait && !is_ld_q[o] &&
                        (rs1_q[o] == rd_q[e] || rs2_q[o] == rd_q[e])) begin
                        rdy[e] = 1'b0;
                    end
                end
            end
        end
    end

    // Oldest-ready pick per class, scanning from head.
    always_comb begin
        logic [TAG_W-1:0] idx;
        idx       = '0;
        alu_found = 1'b0;
        alu_sel   = '0;
        ld_found  = 1'b0;
        ld_sel    = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            idx = head_q + TAG_W'(k);
            if (!alu_found && rdy[idx] && !is_ld_q[idx]) begin
                alu_found = 1'b1;
                alu_sel   = idx;
            end
            if (!ld_found && rdy[idx] && is_ld_q[idx]) begin
                ld_found = 1'b1;
                ld_sel   = idx;
            end
        end
    end

    // Issue, retire and status outputs, zeroed when idle.
    always_comb begin
        alu_valid    = alu_found;
        alu_op       = alu_found ? op_q[alu_sel]  : 3'b000;
        alu_rd       = alu_found ? rd_q[alu_sel]  : 3'b000;
        alu_rs1      = alu_found ? rs1_q[alu_sel] : 3'b000;
        alu_rs2      = alu_found ? rs2_q[alu_sel] : 3'b000;
        alu_tag      = alu_found ? alu_sel        : '0;
        ld_valid     = ld_found;
        ld_rd        = ld_found ? rd_q[ld_sel]  : 3'b000;
        ld_addr      = ld_found ? rs2_q[ld_sel] : 3'b000;
        ld_tag       = ld_found ? ld_sel        : '0;
        retire_valid = (st_q[head_q] == StDone);
        retire_tag   = retire_valid ? head_q : '0;
        count        = count_q;
        halted       = halt_seen_q && (count_q == '0);
    end

    // Next-state: writeback, issue, retire and dispatch touch disjoint entries.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            st_d[i] = st_q[i];
            if (st_q[i] == StIssued &&
                ((alu_wb_valid && alu_wb_tag == TAG_W'(i)) ||
                 (ld_wb_valid && ld_wb_tag == TAG_W'(i)))) begin
                st_d[i] = StDone;
            end
        end
        if (alu_found) begin
            st_d[alu_sel] = StIssued;
        end
        if (ld_found && ld_ready) begin
            st_d[ld_sel] = StIssued;
        end
        if (retire_valid) begin
            st_d[head_q] = StEmpty;
        end
        if (d_alloc) begin
            st_d[tail_q] = StWait;
        end
        head_d      = head_q + TAG_W'(retire_valid);
        tail_d      = tail_q + TAG_W'(d_alloc);
        count_d     = count_q + (TAG_W+1)'(d_alloc) - (TAG_W+1)'(retire_valid);
        halt_seen_d = halt_seen_q || d_halt;
    end

    // State and payload registers; payload is written only on allocation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                st_q[i]    <= StEmpty;
                is_ld_q[i] <= 1'b0;
                op_q[i]    <= 3'b000;
                rd_q[i]    <= 3'b000;
                rs1_q[i]   <= 3'b000;
                rs2_q[i]   <= 3'b000;
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            halt_seen_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                st_q[i] <= st_d[i];
            end
            if (d_alloc) begin
                is_ld_q[tail_q] <= (d_op == OpLd);
                op_q[tail_q]    <= d_op;
                rd_q[tail_q]    <= disp_instr[8:6];
                rs1_q[tail_q]   <= disp_instr[5:3];
                rs2_q[tail_q]   <= disp_instr[2:0];
            end
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            halt_seen_q <= halt_seen_d;
        end
    end

endmodule

// File: tb/tb_ooo_issue_scheduler.sv
// Self-checking bench for ooo_issue_scheduler: directed scenarios plus randomized
// traffic, all compared every cycle against a program-order queue model.
module tb_ooo_issue_scheduler;

    localparam int DEPTH = 4;
    localparam int TAG_W = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             disp_valid = 1'b0;
    logic [11:0]      disp_instr = '0;
    logic             disp_ready;
    logic             alu_valid;
    logic [2:0]       alu_op, alu_rd, alu_rs1, alu_rs2;
    logic [TAG_W-1:0] alu_tag;
    logic             ld_valid;
    logic             ld_ready = 1'b0;
    logic [2:0]       ld_rd, ld_addr;
    logic [TAG_W-1:0] ld_tag;
    logic             alu_wb_valid = 1'b0;
    logic [TAG_W-1:0] alu_wb_tag = '0;
    logic             ld_wb_valid = 1'b0;
    logic [TAG_W-1:0] ld_wb_tag = '0;
    logic             retire_valid;
    logic [TAG_W-1:0] retire_tag;
    logic [TAG_W:0]   count;
    logic             halted;

    int tests_run    = 0;
    int tests_failed = 0;

    ooo_issue_scheduler #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clock(clock), .reset(reset),
        .disp_valid(disp_valid), .disp_instr(disp_instr), .disp_ready(disp_ready),
        .alu_valid(alu_valid), .alu_op(alu_op), .alu_rd(alu_rd), .alu_rs1(alu_rs1),
        .alu_rs2(alu_rs2), .alu_tag(alu_tag),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_addr(ld_addr),
        .ld_tag(ld_tag),
        .alu_wb_valid(alu_wb_valid), .alu_wb_tag(alu_wb_tag),
        .ld_wb_valid(ld_wb_valid), .ld_wb_tag(ld_wb_tag),
        .retire_valid(retire_valid), .retire_tag(retire_tag), .count(count), .halted(halted)
    );

    always #5 clock = ~clock;

    // Reference model: program-order queue; index 0 is the oldest instruction.
    localparam int SWait = 0, SIssued = 1, SDone = 2;
    typedef struct {
        int tag; bit is_ld; int op; int rd; int rs1; int rs2; int st;
    } ment_t;
    ment_t mq[$];
    int    m_tail = 0;
    bit    m_halt = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] mk(input int op, input int rd, input int rs1, input int rs2);
        logic [11:0] v;
        v = {op[2:0], rd[2:0], rs1[2:0], rs2[2:0]};
        return v;
    endfunction

    function automatic bit m_ready(input int e);
        if (mq[e].st != SWait) return 1'b0;
        for (int o = 0; o < e; o++) begin
            if (mq[o].st != SDone) begin
                if (!mq[e].is_ld && (mq[o].rd == mq[e].rs1 || mq[o].rd == mq[e].rs2)) return 1'b0;
                if (mq[o].rd == mq[e].rd) return 1'b0;
            end
            if (mq[o].st == SWait && !mq[o].is_ld &&
                (mq[o].rs1 == mq[e].rd || mq[o].rs2 == mq[e].rd)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int m_pick(input bit want_ld);
        for (int e = 0; e < mq.size(); e++) begin
            if (mq[e].is_ld == want_ld && m_ready(e)) return e;
        end
        return -1;
    endfunction

    function automatic bit m_disp_ready();
        return (mq.size() < DEPTH) && !m_halt;
    endfunction

    task automatic compare_all();
        int a, l;
        logic [14:0] ea, ga;
        logic [8:0]  el, gl;
        logic [2:0]  er, gr;
        a = m_pick(1'b0);
        l = m_pick(1'b1);
        ea = '0;
        if (a >= 0) ea = {1'b1, 3'(mq[a].op), 3'(mq[a].rd), 3'(mq[a].rs1), 3'(mq[a].rs2),
                          2'(mq[a].tag)};
        ga = alu_valid ? {1'b1, alu_op, alu_rd, alu_rs1, alu_rs2, alu_tag} : '0;
        el = '0;
        if (l >= 0) el = {1'b1, 3'(mq[l].rd), 3'(mq[l].rs2), 2'(mq[l].tag)};
        gl = ld_valid ? {1'b1, ld_rd, ld_addr, ld_tag} : '0;
        er = '0;
        if (mq.size() > 0 && mq[0].st == SDone) er = {1'b1, 2'(mq[0].tag)};
        gr = retire_valid ? {1'b1, retire_tag} : '0;
        check("alu_issue", 32'(ga), 32'(ea));
        check("ld_issue", 32'(gl), 32'(el));
        check("retire", 32'(gr), 32'(er));
        check("count", 32'(count), 32'(mq.size()));
        check("disp_ready", 32'(disp_ready), 32'(m_disp_ready()));
        check("halted", 32'(halted), 32'(m_halt && mq.size() == 0));
    endtask

    // Drive one cycle of inputs, advance the model to match, then step past the edge.
    task automatic apply(input bit dv, input logic [11:0] ins, input bit ldr,
                         input bit awv, input int awt, input bit lwv, input int lwt);
        int  a, l;
        bit  ret, acc;
        ment_t n;
        a   = m_pick(1'b0);
        l   = m_pick(1'b1);
        ret = (mq.size() > 0) && (mq[0].st == SDone);
        acc = dv && m_disp_ready();
        disp_valid   = dv;
        disp_instr   = ins;
        ld_ready     = ldr;
        alu_wb_valid = awv;
        alu_wb_tag   = awt[TAG_W-1:0];
        ld_wb_valid  = lwv;
        ld_wb_tag    = lwt[TAG_W-1:0];
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].st == SIssued && ((awv && mq[i].tag == awt) || (lwv && mq[i].tag == lwt)))
                mq[i].st = SDone;
        end
        if (a >= 0) mq[a].st = SIssued;
        if (l >= 0 && ldr) mq[l].st = SIssued;
        if (ret) void'(mq.pop_front());
        if (acc) begin
            if (ins[11:9] <= 3'd5) begin
                n.tag = m_tail; n.is_ld = (ins[11:9] == 3'd5); n.op = int'(ins[11:9]);
                n.rd = int'(ins[8:6]); n.rs1 = int'(ins[5:3]); n.rs2 = int'(ins[2:0]);
                n.st = SWait;
                mq.push_back(n);
                m_tail = (m_tail + 1) % DEPTH;
            end else if (ins[11:9] == 3'd7) begin
                m_halt = 1'b1;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic cyc(input bit dv, input logic [11:0] ins, input bit ldr,
                       input bit awv, input int awt, input bit lwv, input int lwt);
        compare_all();
        apply(dv, ins, ldr, awv, awt, lwv, lwt);
    endtask

    task automatic idle(input bit ldr);
        cyc(1'b0, 12'h000, ldr, 1'b0, 0, 1'b0, 0);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        reset = 1'b1;
        disp_valid = 1'b0; disp_instr = '0; ld_ready = 1'b0;
        alu_wb_valid = 1'b0; alu_wb_tag = '0; ld_wb_valid = 1'b0; ld_wb_tag = '0;
        #1;
        check("rst_disp_ready", 32'(disp_ready), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_outputs", {1'b0, alu_valid, alu_op, alu_rd, alu_rs1, alu_rs2, alu_tag,
                              ld_valid, ld_rd, ld_addr, ld_tag, retire_valid, retire_tag,
                              count, halted}, 32'd0);
        mq.delete();
        m_tail = 0;
        m_halt = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [11:0] prog [8];
        int exp_ret [7];
        int pc, rets, budget;
        int al[$], ll[$];
        bit dv, ldr, awv, lwv;
        int awt, lwt, r, op;

        #2;
        do_reset();

        // RAW: ADD waits on the load's writeback, no bypass.
        cyc(1'b1, mk(5, 0, 0, 0), 1'b1, 1'b0, 0, 1'b0, 0);
        check("raw_ld_issue", {ld_valid, ld_tag, ld_rd}, {1'b1, 2'd0, 3'd0});
        cyc(1'b1, mk(0, 1, 0, 2), 1'b1, 1'b0, 0, 1'b0, 0);
        check("raw_add_blocked0", 32'(alu_valid), 32'd0);
        idle(1'b1);
        check("raw_add_blocked1", 32'(alu_valid), 32'd0);
        cyc(1'b0, 12'h000, 1'b1, 1'b0, 0, 1'b1, 0);
        check("raw_add_issue", {alu_valid, alu_tag, alu_rd}, {1'b1, 2'd1, 3'd1});
        check("raw_retire0", {retire_valid, retire_tag}, {1'b1, 2'd0});
        idle(1'b1);
        cyc(1'b0, 12'h000, 1'b1, 1'b1, 1, 1'b0, 0);
        check("raw_retire1", {retire_valid, retire_tag}, {1'b1, 2'd1});
        idle(1'b1);
        check("raw_empty", 32'(count), 32'd0);

        // Independent ALU op passes a stalled load; then reset with 3 entries in flight.
        do_reset();
        cyc(1'b1, mk(5, 0, 0, 0), 1'b0, 1'b0, 0, 1'b0, 0);
        cyc(1'b1, mk(1, 4, 5, 3), 1'b0, 1'b0, 0, 1'b0, 0);
        check("byp_sub_issue", {alu_valid, alu_op, alu_rd, alu_tag}, {1'b1, 3'd1, 3'd4, 2'd1});
        check("byp_ld_stalled", {ld_valid, ld_tag}, {1'b1, 2'd0});
        cyc(1'b1, mk(3, 6, 6, 6), 1'b0, 1'b0, 0, 1'b0, 0);
        check("byp_count3", 32'(count), 32'd3);
        do_reset();
        cyc(1'b0, 12'h000, 1'b0, 1'b1, 1, 1'b1, 0);

        // WAW/WAR: OR and AND wait behind an unissued SUB that waits on a load.
        do_reset();
        cyc(1'b1, mk(5, 5, 0, 1), 1'b0, 1'b0, 0, 1'b0, 0);
        cyc(1'b1, mk(1, 4, 5, 3), 1'b0, 1'b0, 0, 1'b0, 0);
        cyc(1'b1, mk(3, 4, 6, 7), 1'b0, 1'b0, 0, 1'b0, 0);
        cyc(1'b1, mk(2, 3, 7, 6), 1'b0, 1'b0, 0, 1'b0, 0);
        check("hz_wait0", 32'(alu_valid), 32'd0);
        idle(1'b0);
        check("hz_wait1", 32'(alu_valid), 32'd0);
        idle(1'b1);
        cyc(1'b0, 12'h000, 1'b0, 1'b0, 0, 1'b1, 0);
        check("hz_sub_first", {alu_valid, alu_op, alu_tag}, {1'b1, 3'd1, 2'd1});
        idle(1'b0);
        check("hz_and_next", {alu_valid, alu_op, alu_tag}, {1'b1, 3'd2, 2'd3});
        cyc(1'b0, 12'h000, 1'b0, 1'b1, 1, 1'b0, 0);
        check("hz_or_last", {alu_valid, alu_op, alu_tag}, {1'b1, 3'd3, 2'd2});
        cyc(1'b0, 12'h000, 1'b0, 1'b1, 3, 1'b0, 0);
        cyc(1'b0, 12'h000, 1'b0, 1'b1, 2, 1'b0, 0);
        for (int i = 0; i < 3; i++) idle(1'b0);
        check("hz_drained", 32'(count), 32'd0);

        // Full window, then wrap of the tail back to tag 0.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, mk(5, 4 + i, 0, i), 1'b0, 1'b0, 0, 1'b0, 0);
        check("full_count", {count, disp_ready}, {3'd4, 1'b0});
        cyc(1'b1, mk(0, 1, 2, 3), 1'b0, 1'b0, 0, 1'b0, 0);
        check("full_no_accept", 32'(count), 32'd4);
        idle(1'b1);
        cyc(1'b0, 12'h000, 1'b0, 1'b0, 0, 1'b1, 0);
        check("full_retire", {retire_valid, retire_tag, disp_ready}, {1'b1, 2'd0, 1'b0});
        idle(1'b0);
        check("full_reopen", {disp_ready, count}, {1'b1, 3'd3});
        cyc(1'b1, mk(0, 1, 2, 3), 1'b0, 1'b0, 0, 1'b0, 0);
        check("wrap_tag", {alu_valid, alu_tag}, {1'b1, 2'd0});
        idle(1'b0);

        // Seven-instruction program followed by HALT.
        do_reset();
        prog = '{mk(5, 1, 0, 2), mk(0, 2, 1, 1), mk(1, 3, 2, 1), mk(3, 4, 5, 6),
                 mk(5, 5, 0, 3), mk(4, 6, 4, 5), mk(2, 7, 6, 3), mk(7, 0, 0, 0)};
        exp_ret = '{0, 1, 2, 3, 0, 1, 2};
        pc = 0; rets = 0; budget = 0;
        while (rets < 7 && budget < 200) begin
            budget++;
            compare_all();
            if (retire_valid) begin
                check("prog_retire_tag", 32'(retire_tag), 32'(exp_ret[rets]));
                rets++;
            end
            awv = 1'b0; awt = 0; lwv = 1'b0; lwt = 0;
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].st == SIssued && !mq[i].is_ld) begin awv = 1'b1; awt = mq[i].tag; end
                if (mq[i].st == SIssued && mq[i].is_ld) begin lwv = 1'b1; lwt = mq[i].tag; end
            end
            dv = (pc < 8);
            r  = (dv && m_disp_ready()) ? 1 : 0;
            apply(dv, dv ? prog[pc] : 12'h000, 1'b1, awv, awt, lwv, lwt);
            pc += r;
        end
        check("prog_all_retired", 32'(rets), 32'd7);
        check("prog_halted", {halted, disp_ready, count}, {1'b1, 1'b0, 3'd0});
        idle(1'b0);
        check("prog_halt_sticky", {halted, disp_ready}, {1'b1, 1'b0});

        // Randomized traffic with hazards concentrated on a few registers.
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            for (int c = 0; c < 300; c++) begin
                r  = $urandom_range(0, 99);
                if (ep >= 2 && r < 1) op = 7;
                else if (r < 4) op = 6;
                else if (r < 30) op = 5;
                else op = $urandom_range(0, 4);
                dv  = ($urandom_range(0, 3) != 0);
                ldr = ($urandom_range(0, 2) != 0);
                al.delete(); ll.delete();
                foreach (mq[i]) begin
                    if (mq[i].st == SIssued && !mq[i].is_ld) al.push_back(mq[i].tag);
                    if (mq[i].st == SIssued && mq[i].is_ld) ll.push_back(mq[i].tag);
                end
                awv = (al.size() > 0) && ($urandom_range(0, 1) == 1);
                awt = awv ? al[$urandom_range(0, al.size() - 1)] : 0;
                lwv = (ll.size() > 0) && ($urandom_range(0, 1) == 1);
                lwt = lwv ? ll[$urandom_range(0, ll.size() - 1)] : 0;
                if ($urandom_range(0, 9) == 0) begin awv = 1'b1; awt = $urandom_range(0, 3); end
                if (awv && lwv && awt == lwt) lwv = 1'b0;
                cyc(dv, mk(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7)),
                    ldr, awv, awt, lwv, lwt);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ooo_issue_scheduler.md
Name: ooo_issue_scheduler

Overview:
- Dispatch/issue scheduler between the 12-bit instruction input and the execution units of the out-of-order core.
- Holds dispatched instructions in an age-ordered circular window and issues at most one ALU op and one LD per cycle, oldest-ready first.
- Enforces RAW, WAR and WAW ordering against older entries.
- Tracks completion and retires in program order; handles HALT.

Parameters:
DEPTH, 4, window entries; power of 2, 2..8
TAG_W, 2, log2(DEPTH); entry index width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
disp_valid  in  1  instruction present on disp_instr
disp_instr  in  12  {op[11:9], rd[8:6], rs1[5:3], rs2[2:0]}
disp_ready  out  1  window accepts dispatch this cycle
alu_valid  out  1  ALU issue this cycle; always accepted
alu_op  out  3  opcode 000..100
alu_rd, alu_rs1, alu_rs2  out  3 each  register indices
alu_tag  out  TAG_W  issuing entry index
ld_valid  out  1  LD issue request
ld_ready  in  1  load unit accepts request
ld_rd  out  3  destination register
ld_addr  out  3  memory address (= rs2 field)
ld_tag  out  TAG_W  issuing entry index
alu_wb_valid, ld_wb_valid  in  1 each  completion strobes
alu_wb_tag, ld_wb_tag  in  TAG_W each  completing entry
retire_valid  out  1  head entry retired this cycle
retire_tag  out  TAG_W  retired entry index
count  out  TAG_W+1  occupied entries
halted  out  1  HALT seen and window empty

Behaviour:
- Reset (async): all entries EMPTY; head=tail=0; halt_seen=0; every output 0 except disp_ready=1. Applies mid-operation and discards in-flight entries. Later wb strobes are ignored.
- Entry states: EMPTY -> WAIT (dispatch) -> ISSUED (issue handshake) -> DONE (matching wb) -> EMPTY (retire at head).
- Decode:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR: ALU, sources rs1 and rs2.
  - 101 LD: load class, no register sources, addr = rs2 field.
  - 111 HALT: not allocated; sets halt_seen.
  - 110: accepted and dropped, with no entry.
- disp_ready = (count < DEPTH) && !halt_seen. No same-cycle retire credit.
- Dispatch fires when disp_valid && disp_ready: entry written at tail on the edge; tail += 1 mod DEPTH.
- Age: older = smaller distance from head, modulo DEPTH.
- Entry E is ready when it is in WAIT and, for every older non-EMPTY, non-DONE entry O:
  - O.rd is not any source of E (RAW);
  - O.rd != E.rd (WAW).
  - Additionally, for every older entry O in WAIT, no source of O equals E.rd (WAR).
  - Only ALU entries have sources.
- Issue outputs are combinational from registered state:
  - The oldest ready ALU entry drives alu_*; alu_valid=1; the entry goes to ISSUED on that edge.
  - The oldest ready LD entry drives ld_*; it goes to ISSUED only on an edge where ld_valid && ld_ready. It holds while stalled; the fields stay stable.
- Completion:
  - A wb strobe on an ISSUED entry marks it DONE on the edge. Wb strobes on non-ISSUED tags are ignored.
  - Both wb ports may fire in the same cycle (different tags).
  - No bypass: a dependent becomes ready the cycle after its producer's wb edge.
- Retire:
  - If the head is DONE: retire_valid=1 and retire_tag=head (combinational). On the edge, head is freed and head += 1.
  - At most one retire per cycle.
- Simultaneous events:
  - Dispatch, ALU issue, LD issue, two wb strobes and a retire may all occur on one edge.
  - count = count + dispatch - retire.
- Full: count==DEPTH, so disp_ready=0 while issue, wb and retire continue. Empty: no issue, no retire.
- Wrap: head and tail wrap modulo DEPTH; count distinguishes full from empty.
- HALT: halt_seen stays set until reset. halted = halt_seen && count==0 (combinational).

Test Plan:
- Reset mid-run: assert reset with 3 entries in the window -> count=0, alu_valid=0, ld_valid=0, retire_valid=0, disp_ready=1 immediately (async).
- RAW: LD R0,MEM[0] then ADD R1,R0,R2, with ld_ready=1 and ld_wb two cycles after LD issue -> LD issues the cycle after dispatch. ADD issues exactly one cycle after the LD wb edge. Retire order is tags 0, 1.
- Independent bypass: SUB R4,R5,R3 dispatched behind a stalled LD (ld_ready=0) -> SUB issues the next cycle with alu_op=001, alu_rd=4.
- WAW/WAR: SUB R4,R5,R3; OR R4,R6,R7; AND R3,R7,R6 with SUB unissued (older LD holding R5: LD R5) -> OR and AND both wait. After the LD completes, SUB issues first, then OR and AND in later cycles.
- Full window, DEPTH=4: four LDs with ld_ready=0 -> count=4, disp_ready=0. A fifth disp_valid is not accepted. Complete tag 0 -> retire_valid; the next cycle disp_ready=1 and the new entry gets tag 0 (wrap).
- Full seven-instruction program plus HALT (LD, ADD, SUB, OR, LD, XOR, AND, HALT) -> disp_ready=0 after HALT. All 7 retire in order with tags 0,1,2,3,0,1,2. halted=1 in the cycle after the last retire.
